// File: rtl/result_reader.sv
// Unloads a rows x cols result matrix from data memory after the core signals
// END, streaming the elements row-major over a valid/ready output port.
module result_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              END,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        rows,
  input  logic [7:0]        cols,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg
);
  // Handshake: an element transfers on a rising edge where out_valid and
  // out_ready are both high; out_data and out_last hold while out_ready is low.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic              end_q;
  logic              armed;
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       total;
  logic [15:0]       index;
  logic [15:0]       req_total;
  logic              start;
  logic              last;
  logic              xfer;

  assign req_total = 16'(rows) * 16'(cols);
  // armed blocks a start until END has been seen low since reset
  assign start     = END & ~end_q & armed & (state == IDLE);
  assign last      = (index == total - 16'd1);
  assign xfer      = (state == SEND) & out_ready;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (RESET) begin
      state    <= IDLE;
      end_q    <= 1'b0;
      armed    <= ~END;
      base_q   <= '0;
      total    <= '0;
      index    <= '0;
      out_data <= '0;
    end else begin
      state <= state_nx;
      end_q <= END;
      armed <= armed | ~END;
      if (start && req_total != 16'd0) begin
        base_q <= base_addr;
        total  <= req_total;
        index  <= '0;
      end
      if (state == WAIT) begin
        out_data <= mem_rdata;
      end
      if (xfer && !last) begin
        index <= index + 16'd1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    mem_read  = 1'b0;
    mem_addr  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nx = (req_total == 16'd0) ? FIN : READ;
        end
      end
      READ: begin
        mem_read = 1'b1;
        mem_addr = base_q + ADDR_W'(index);
        state_nx = WAIT;
      end
      WAIT: begin
        state_nx = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = last;
        if (out_ready) begin
          state_nx = last ? FIN : READ;
        end
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule
